shift_operand_issue: RTL and testbench
======================================

Name: shift_operand_issue

Overview:
- Issue stage directly upstream of the 32-bit barrel left shifter in the ALU shift path.
- Accepts shift requests over a valid/ready handshake and buffers them in a 2-entry FIFO.
- Normalises every request into a left-shift form:
  - masks the shift amount to 5 bits;
  - bit-reverses operand A for right shifts;
  - emits sideband flags so the result stage can un-reverse and sign-fill.
- Decouples the shifter from operand-delivery stalls.

Parameters:
- TAG_W, 4, width of the request tag carried alongside each operation.
- DEPTH, 2, FIFO entries; fixed at 2, other values are unsupported.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous reset, active-high.
- flush_i  in  1  synchronous flush: empties the FIFO; does not clear err_cnt_o.
- in_valid_i  in  1  request valid.
- in_ready_o  out  1  stage can accept a request this cycle.
- in_op_i  in  4  operation code.
- in_a_i  in  32  value to shift.
- in_b_i  in  32  shift amount; only bits [4:0] are used.
- in_tag_i  in  TAG_W  request tag.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  downstream consumes the head entry.
- alu_op_o  out  4  op presented to the shifter; always SHIFT_OP_SLL when valid.
- alu_a_o  out  32  normalised operand A.
- alu_b_o  out  32  {27'b0, amount[4:0]}.
- rev_o  out  1  result must be bit-reversed downstream (SRL/SRA).
- sign_o  out  1  vacated bits must be one-filled downstream (SRA with A[31]=1).
- tag_o  out  TAG_W  tag of the head entry.
- err_cnt_o  out  8  saturating count of dropped illegal ops.

Behaviour:
- Reset: FIFO empty, out_valid_o=0, in_ready_o=1, err_cnt_o=0.
  - All payload outputs (alu_op_o, alu_a_o, alu_b_o, rev_o, sign_o, tag_o) are 0.
- in_ready_o = (count < 2). It is a registered-count decode with no combinational path from out_ready_i.
  - When full, a same-cycle pop does not enable a push.
- Push = in_valid_i & in_ready_o. Pop = out_valid_o & out_ready_i.
- Push and pop in the same cycle: count unchanged, head advances, the new entry is written at the tail.
- out_valid_o = (count != 0). All out_* payloads are driven straight from head-entry registers.
- Latency: an accepted request appears on out_valid_o the next cycle when the FIFO was empty.
- Throughput is 1 per cycle while out_ready_i stays high.
- Head payload is stable while out_valid_o=1 and out_ready_i=0.
- Pointers are 1-bit wrap-around read/write indices with a 2-bit count (0..2).
- Op decode happens at push, and the decoded form is stored:
  - SHIFT_OP_SLL (4'b0001): alu_a = A, rev=0, sign=0.
  - SHIFT_OP_SRL (4'b0010): alu_a = bitrev(A), rev=1, sign=0.
  - SHIFT_OP_SRA (4'b0011): alu_a = bitrev(A), rev=1, sign=A[31].
- Any other op code is illegal:
  - It is accepted (in_ready_o obeyed) but not written to the FIFO.
  - err_cnt_o increments by 1 and saturates at 8'hFF.
- flush_i:
  - Next cycle count=0, pointers=0, out_valid_o=0.
  - It wins over push and pop in the same cycle; a push presented during flush is discarded and is not counted as an error even if illegal.
- rst_i has priority over flush_i.
- Reset asserted mid-operation discards all entries at the next edge.

Decomposition:
- Package shift_pkg holds:
  - SHIFT_OP_SLL, SHIFT_OP_SRL and SHIFT_OP_SRA constants (4-bit);
  - a packed struct shift_req_t {a[31:0], amt[4:0], rev, sign, tag};
  - function bitrev32.
- One natural sub-module, shift_req_fifo: the 2-entry FIFO of shift_req_t with count and pointers, parameterised on payload width.
- Decode and the error counter stay in the top module.

Test Plan:
- Reset, then single SLL (A=32'h0000_00F1, B=32'h0000_0024, tag=3) with out_ready_i=1 -> next cycle:
  - out_valid_o=1, alu_a_o=32'h0000_00F1, alu_b_o=32'h4;
  - rev_o=0, sign_o=0, tag_o=3, alu_op_o=4'b0001.
- SRA with A=32'h8000_0010, B=5 -> alu_a_o=32'h0800_0001, alu_b_o=5, rev_o=1, sign_o=1.
  - SRL with the same A -> identical except sign_o=0.
- Hold out_ready_i=0 and push 3 back-to-back requests (tags 1,2,3):
  - in_ready_o drops after the 2nd; tag 3 waits;
  - releasing out_ready_i yields tags 1,2,3 in order with no loss or duplication.
- Full FIFO with in_valid_i=1 and out_ready_i=1 in the same cycle -> pop occurs, no push (in_ready_o=0); count=1 next cycle.
- Three illegal ops (4'b0111) -> err_cnt_o=3, out_valid_o stays 0.
  - Preload err_cnt_o to 255 via 255 illegal ops, then one more -> stays 8'hFF.
- Two entries queued, flush_i=1 together with a legal push -> next cycle out_valid_o=0 and in_ready_o=1; the pushed request never appears.
  - rst_i during traffic -> all outputs 0 next cycle.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared opcodes, the stored request format and the bit-reverse helper for the shift issue stage.
package shift_pkg;

    localparam logic [3:0] SHIFT_OP_SLL = 4'b0001;
    localparam logic [3:0] SHIFT_OP_SRL = 4'b0010;
    localparam logic [3:0] SHIFT_OP_SRA = 4'b0011;

    localparam int unsigned SHIFT_TAG_W = 4;

    // Request already normalised to left-shift form, as held in the FIFO.
    typedef struct packed {
        logic [31:0]            a;
        logic [4:0]             amt;
        logic                   rev;
        logic                   sign;
        logic [SHIFT_TAG_W-1:0] tag;
    } shift_req_t;

    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_req_fifo.sv
// Two-entry FIFO with 1-bit wrap-around pointers and a 0..2 occupancy count.
module shift_req_fifo #(
    parameter int unsigned WIDTH = 43,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [1:0]       count_o
);

    if (DEPTH != 2) begin : g_depth_check
        $error("shift_req_fifo supports DEPTH == 2 only");
    end

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_count;
    logic [1:0]       w_count_d;
    logic             w_push;
    logic             w_pop;

    // Full blocks push even when a pop happens in the same cycle.
    assign w_push = push_i & (r_count != 2'd2);
    assign w_pop  = pop_i & (r_count != 2'd0);

    always_comb begin
        w_count_d = r_count;
        unique case ({w_push, w_pop})
            2'b10:   w_count_d = r_count + 2'd1;
            2'b01:   w_count_d = r_count - 2'd1;
            default: w_count_d = r_count;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
        end else if (flush_i) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= wdata_i;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= w_count_d;
        end
    end

    assign rdata_o = r_mem[r_rptr];
    assign count_o = r_count;

endmodule

// File: rtl/shift_operand_issue.sv
// Issue stage ahead of the left barrel shifter: decodes shift ops into left-shift form and buffers them.
module shift_operand_issue
    import shift_pkg::*;
#(
    parameter int unsigned TAG_W = 4,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [3:0]       in_op_i,
    input  logic [31:0]      in_a_i,
    input  logic [31:0]      in_b_i,
    input  logic [TAG_W-1:0] in_tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [3:0]       alu_op_o,
    output logic [31:0]      alu_a_o,
    output logic [31:0]      alu_b_o,
    output logic             rev_o,
    output logic             sign_o,
    output logic [TAG_W-1:0] tag_o,
    output logic [7:0]       err_cnt_o
);

    if (TAG_W != SHIFT_TAG_W) begin : g_tag_w_check
        $error("TAG_W must match shift_pkg::SHIFT_TAG_W");
    end

    logic       w_legal;
    logic       w_accept;
    logic       w_push;
    logic       w_pop;
    logic [1:0] w_count;
    logic [7:0] r_err_cnt;
    logic       w_unused_b;
    shift_req_t w_req;
    shift_req_t w_head;

    assign w_unused_b = ^in_b_i[31:5];

    assign w_legal = (in_op_i == SHIFT_OP_SLL) | (in_op_i == SHIFT_OP_SRL) |
                     (in_op_i == SHIFT_OP_SRA);

    // Ready is a pure decode of the registered count, never of out_ready_i.
    assign in_ready_o  = (w_count != 2'd2);
    assign out_valid_o = (w_count != 2'd0);
    assign w_accept    = in_valid_i & in_ready_o;
    assign w_push      = w_accept & w_legal & ~flush_i;
    assign w_pop       = out_valid_o & out_ready_i;

    always_comb begin
        w_req      = '0;
        w_req.amt  = in_b_i[4:0];
        w_req.tag  = in_tag_i;
        w_req.a    = in_a_i;
        if (in_op_i == SHIFT_OP_SRL || in_op_i == SHIFT_OP_SRA) begin
            w_req.a   = bitrev32(in_a_i);
            w_req.rev = 1'b1;
        end
        if (in_op_i == SHIFT_OP_SRA) begin
            w_req.sign = in_a_i[31];
        end
    end

    shift_req_fifo #(
        .WIDTH ($bits(shift_req_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .wdata_i (w_req),
        .rdata_o (w_head),
        .count_o (w_count)
    );

    // Illegal ops are consumed but only counted; a flush discards them uncounted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err_cnt <= 8'd0;
        end else if (w_accept && !w_legal && !flush_i && r_err_cnt != 8'hFF) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_cnt_o = r_err_cnt;
    assign alu_op_o  = out_valid_o ? SHIFT_OP_SLL : 4'b0000;
    assign alu_a_o   = w_head.a;
    assign alu_b_o   = {27'b0, w_head.amt};
    assign rev_o     = w_head.rev;
    assign sign_o    = w_head.sign;
    assign tag_o     = w_head.tag;

endmodule

// File: tb/tb_shift_operand_issue.sv
// Scoreboard bench for shift_operand_issue: model queue of expected head entries plus directed scenarios.
module tb_shift_operand_issue;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready, rev, sign;
    logic [3:0]  in_op, in_tag, alu_op, tag;
    logic [31:0] in_a, in_b, alu_a, alu_b;
    logic [7:0]  err_cnt;

    typedef struct packed {
        logic [31:0] a;
        logic [4:0]  amt;
        logic        rev;
        logic        sign;
        logic [3:0]  tag;
    } exp_t;

    exp_t q[$];
    int   m_err = 0;
    bit   m_acc;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    shift_operand_issue #(.TAG_W(4), .DEPTH(2)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_op_i     (in_op),
        .in_a_i      (in_a),
        .in_b_i      (in_b),
        .in_tag_i    (in_tag),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .alu_op_o    (alu_op),
        .alu_a_o     (alu_a),
        .alu_b_o     (alu_b),
        .rev_o       (rev),
        .sign_o      (sign),
        .tag_o       (tag),
        .err_cnt_o   (err_cnt)
    );

    function automatic exp_t model_req(logic [3:0] op, logic [31:0] a, logic [31:0] b,
                                       logic [3:0] t);
        exp_t e;
        e.rev  = (op != 4'b0001);
        e.sign = (op == 4'b0011) && a[31];
        e.amt  = b[4:0];
        e.tag  = t;
        for (int i = 0; i < 32; i++) e.a[i] = e.rev ? a[31-i] : a[i];
        return e;
    endfunction

    function automatic bit is_legal(logic [3:0] op);
        return (op == 4'b0001) || (op == 4'b0010) || (op == 4'b0011);
    endfunction

    // One clock; model state follows the inputs present at the edge.
    task automatic tick();
        bit   acc, pop;
        exp_t e;
        acc = in_valid && (q.size() < 2) && !flush && !rst;
        pop = (q.size() != 0) && out_ready;
        e   = model_req(in_op, in_a, in_b, in_tag);
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_err = 0;
        end else if (flush) begin
            q.delete();
        end else begin
            if (pop) q.delete(0);
            if (acc) begin
                if (is_legal(in_op)) q.push_back(e);
                else if (m_err < 255) m_err++;
            end
        end
        m_acc = acc;
        #1;
    endtask

    task automatic test_reset();
        rst = 1; flush = 0; in_valid = 0; out_ready = 0;
        in_op = 0; in_a = 0; in_b = 0; in_tag = 0;
        tick(); tick();
        rst = 0;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
        checks++;
        if (err_cnt !== 8'd0) begin failures++; $display("FAIL reset_err got=%h exp=00", err_cnt); end
        checks++;
        if ({alu_op, alu_a, alu_b, rev, sign, tag} !== 78'd0) begin
            failures++;
            $display("FAIL reset_payload got=%h exp=0", {alu_op, alu_a, alu_b, rev, sign, tag});
        end
    endtask

    task automatic test_single_sll();
        out_ready = 1; in_valid = 1; in_op = 4'b0001;
        in_a = 32'h0000_00F1; in_b = 32'h0000_0024; in_tag = 4'd3;
        tick();
        in_valid = 0;
        checks++;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL sll_valid got=%b exp=1", out_valid); end
        checks++;
        if ({alu_op, alu_a, alu_b, rev, sign, tag} !==
            {4'b0001, 32'h0000_00F1, 32'h0000_0004, 1'b0, 1'b0, 4'd3}) begin
            failures++;
            $display("FAIL sll_payload got=%h/%h/%h/%b%b/%h exp=1/000000f1/00000004/00/3",
                     alu_op, alu_a, alu_b, rev, sign, tag);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL sll_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_sra_srl();
        out_ready = 1; in_valid = 1; in_op = 4'b0011;
        in_a = 32'h8000_0010; in_b = 32'd5; in_tag = 4'd5;
        tick();
        in_op = 4'b0010; in_tag = 4'd6;
        checks++;
        if ({alu_a, alu_b, rev, sign, tag} !== {32'h0800_0001, 32'd5, 1'b1, 1'b1, 4'd5}) begin
            failures++;
            $display("FAIL sra got=%h/%h/%b%b/%h exp=08000001/00000005/11/5", alu_a, alu_b, rev, sign, tag);
        end
        tick();
        in_valid = 0;
        checks++;
        if ({alu_a, alu_b, rev, sign, tag} !== {32'h0800_0001, 32'd5, 1'b1, 1'b0, 4'd6}) begin
            failures++;
            $display("FAIL srl got=%h/%h/%b%b/%h exp=08000001/00000005/10/6", alu_a, alu_b, rev, sign, tag);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [3:0] got[$];
        out_ready = 0; in_valid = 1; in_op = 4'b0001; in_b = 32'd1;
        in_a = 32'h1111_0001; in_tag = 4'd1;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready1 got=%b exp=1", in_ready); end
        in_a = 32'h2222_0002; in_tag = 4'd2;
        tick();
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready2 got=%b exp=0", in_ready); end
        in_a = 32'h3333_0003; in_tag = 4'd3;
        tick(); tick();
        checks++;
        if ({tag, alu_a, in_ready} !== {4'd1, 32'h1111_0001, 1'b0}) begin
            failures++;
            $display("FAIL b2b_hold got=%h/%h/%b exp=1/11110001/0", tag, alu_a, in_ready);
        end
        out_ready = 1;
        for (int c = 0; c < 8; c++) begin
            if (out_valid) got.push_back(tag);
            tick();
            if (m_acc) in_valid = 0;
        end
        checks++;
        if (got.size() != 3) begin
            failures++;
            $display("FAIL b2b_count got=%0d exp=3", got.size());
        end else begin
            checks++;
            if ({got[0], got[1], got[2]} !== 12'h123) begin
                failures++;
                $display("FAIL b2b_order got=%h%h%h exp=123", got[0], got[1], got[2]);
            end
        end
    endtask

    task automatic test_full_pop();
        out_ready = 0; in_valid = 1; in_op = 4'b0001; in_a = 32'hA5; in_tag = 4'd4;
        tick();
        in_tag = 4'd5;
        tick();
        in_tag = 4'd6; out_ready = 1;
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", in_ready); end
        tick();
        in_valid = 0; out_ready = 0;
        checks++;
        if ({out_valid, tag, in_ready} !== {1'b1, 4'd5, 1'b1}) begin
            failures++;
            $display("FAIL full_pop got=%b/%h/%b exp=1/5/1", out_valid, tag, in_ready);
        end
        out_ready = 1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL full_nopush got=%b exp=0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 0; in_valid = 1; in_op = 4'b0001; in_a = 32'h77; in_tag = 4'd7;
        tick();
        in_tag = 4'd8;
        tick();
        flush = 1; in_tag = 4'd9;
        tick();
        flush = 0; in_valid = 0;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            failures++;
            $display("FAIL flush_state got=%b%b exp=01", out_valid, in_ready);
        end
        // Flush on an empty FIFO must also discard a legal push.
        flush = 1; in_valid = 1; in_tag = 4'd10;
        tick();
        flush = 0; in_valid = 0; out_ready = 1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_push got=%b exp=0", out_valid); end
        flush = 1; in_valid = 1; in_op = 4'b0111;
        tick();
        flush = 0; in_valid = 0;
        checks++;
        if (err_cnt !== 8'd0) begin failures++; $display("FAIL flush_illegal got=%h exp=00", err_cnt); end
    endtask

    task automatic test_illegal();
        out_ready = 1; in_valid = 1; in_op = 4'b0111; in_a = 32'hDEAD; in_tag = 4'd2;
        repeat (3) tick();
        checks++;
        if (err_cnt !== 8'd3) begin failures++; $display("FAIL illegal_cnt got=%h exp=03", err_cnt); end
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL illegal_valid got=%b exp=0", out_valid); end
        repeat (252) tick();
        checks++;
        if (err_cnt !== 8'hFF) begin failures++; $display("FAIL illegal_255 got=%h exp=ff", err_cnt); end
        tick();
        in_valid = 0;
        checks++;
        if (err_cnt !== 8'hFF) begin failures++; $display("FAIL illegal_sat got=%h exp=ff", err_cnt); end
    endtask

    task automatic test_reset_mid();
        out_ready = 0; in_valid = 1; in_op = 4'b0011; in_a = 32'hFFFF_0000; in_b = 32'd9;
        in_tag = 4'd11;
        tick();
        in_tag = 4'd12;
        tick();
        rst = 1;
        tick();
        rst = 0; in_valid = 0;
        checks++;
        if ({out_valid, in_ready, err_cnt} !== {1'b0, 1'b1, 8'd0}) begin
            failures++;
            $display("FAIL rstmid_ctrl got=%b/%b/%h exp=0/1/00", out_valid, in_ready, err_cnt);
        end
        checks++;
        if ({alu_op, alu_a, alu_b, rev, sign, tag} !== 78'd0) begin
            failures++;
            $display("FAIL rstmid_payload got=%h exp=0", {alu_op, alu_a, alu_b, rev, sign, tag});
        end
    endtask

    task automatic test_random();
        logic [3:0] ops [5];
        exp_t       e;
        ops[0] = 4'b0001; ops[1] = 4'b0010; ops[2] = 4'b0011; ops[3] = 4'b0111; ops[4] = 4'b0000;
        for (int c = 0; c < 300; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            in_op     = ops[$urandom_range(0, 4)];
            in_a      = $urandom;
            in_b      = $urandom;
            in_tag    = 4'($urandom_range(0, 15));
            tick();
            checks++;
            if ({out_valid, in_ready} !== {q.size() != 0, q.size() < 2}) begin
                failures++;
                $display("FAIL rnd_ctrl c=%0d got=%b%b exp=%b%b", c, out_valid, in_ready,
                         q.size() != 0, q.size() < 2);
            end
            checks++;
            if (err_cnt !== 8'(m_err)) begin
                failures++;
                $display("FAIL rnd_err c=%0d got=%h exp=%h", c, err_cnt, 8'(m_err));
            end
            if (q.size() != 0) begin
                e = q[0];
                checks++;
                if ({alu_op, alu_a, alu_b, rev, sign, tag} !==
                    {4'b0001, e.a, 27'b0, e.amt, e.rev, e.sign, e.tag}) begin
                    failures++;
                    $display("FAIL rnd_head c=%0d got=%h/%h/%h/%b%b/%h exp=1/%h/%h/%b%b/%h", c,
                             alu_op, alu_a, alu_b, rev, sign, tag, e.a, {27'b0, e.amt},
                             e.rev, e.sign, e.tag);
                end
            end
        end
        in_valid = 0; flush = 0;
    endtask

    initial begin
        test_reset();
        test_single_sll();
        test_sra_srl();
        test_back_to_back();
        test_full_pop();
        test_flush();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
